// File: rtl/ctl_pkg.sv
// Shared constants and state encodings for the ctl_pipe elastic handshake buffer.
// Protocol selectors are compared against the IN_PHASES / OUT_PHASES parameters.
package ctl_pkg;

    localparam int PH_4 = 4;
    localparam int PH_2 = 2;

    typedef enum logic {
        I_IDLE,
        I_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_REQ,
        O_RTZ
    } out_state_t;

    function automatic bit phases_ok(input int phases);
        return (phases == PH_4) || (phases == PH_2);
    endfunction

endpackage

// File: rtl/ctl_fifo.sv
// Circular token store for ctl_pipe: array storage, wrapping pointers, registered
// occupancy flags and a registered head-read port that updates only on load.
module ctl_fifo
    import ctl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       load,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             full_reg;
    logic             empty_reg;
    logic [WIDTH-1:0] head_reg;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            head_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
            if (load) begin
                head_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign head_data = head_reg;
    assign count     = count_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;

endmodule

// File: rtl/ctl_pipe.sv
// Elastic req/ack buffer: upstream and downstream channels each run 4-phase or
// 2-phase signalling, with optional two-flop synchronisers on req_i and ack_o.
module ctl_pipe #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int IN_PHASES   = 4,
    parameter int OUT_PHASES  = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ack_i,
    output logic                       req_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       ack_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    import ctl_pkg::*;

    if (!phases_ok(IN_PHASES)) begin : g_bad_in
        $fatal(1, "ctl_pipe: IN_PHASES must be 2 or 4");
    end
    if (!phases_ok(OUT_PHASES)) begin : g_bad_out
        $fatal(1, "ctl_pipe: OUT_PHASES must be 2 or 4");
    end
    if (SYNC_STAGES != 0 && SYNC_STAGES != 2) begin : g_bad_sync
        $fatal(1, "ctl_pipe: SYNC_STAGES must be 0 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ctl_pipe: DEPTH must be a power of two >= 2");
    end

    logic       req_s;
    logic       ack_s;
    in_state_t  in_state_reg;
    in_state_t  in_state_next;
    out_state_t out_state_reg;
    out_state_t out_state_next;
    logic       ack_reg;
    logic       ack_next;
    logic       req_reg;
    logic       req_next;
    logic       push;
    logic       pop;
    logic       load;
    logic       fifo_full;
    logic       fifo_empty;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign req_s = req_i;
        assign ack_s = ack_o;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] req_sync_reg;
        logic [SYNC_STAGES-1:0] ack_sync_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                req_sync_reg <= '0;
                ack_sync_reg <= '0;
            end else begin
                req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], req_i};
                ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_o};
            end
        end

        assign req_s = req_sync_reg[SYNC_STAGES-1];
        assign ack_s = ack_sync_reg[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_state_reg  <= I_IDLE;
            out_state_reg <= O_IDLE;
            ack_reg       <= 1'b0;
            req_reg       <= 1'b0;
        end else begin
            in_state_reg  <= in_state_next;
            out_state_reg <= out_state_next;
            ack_reg       <= ack_next;
            req_reg       <= req_next;
        end
    end

    // Upstream side. Full is the registered flag, so a pop in the same cycle
    // does not open a slot until the following edge.
    always_comb begin
        in_state_next = in_state_reg;
        ack_next      = ack_reg;
        push          = 1'b0;
        if (IN_PHASES == PH_2) begin
            if ((req_s != ack_reg) && !fifo_full) begin
                push     = 1'b1;
                ack_next = !ack_reg;
            end
        end else begin
            case (in_state_reg)
                I_IDLE: begin
                    if (req_s && !fifo_full) begin
                        push          = 1'b1;
                        ack_next      = 1'b1;
                        in_state_next = I_ACK;
                    end
                end
                I_ACK: begin
                    if (!req_s) begin
                        ack_next      = 1'b0;
                        in_state_next = I_IDLE;
                    end
                end
                default: in_state_next = I_IDLE;
            endcase
        end
    end

    // Downstream side. ack_s is only looked at while a request is outstanding
    // (or during return-to-zero), so stray activity elsewhere is ignored.
    always_comb begin
        out_state_next = out_state_reg;
        req_next       = req_reg;
        load           = 1'b0;
        pop            = 1'b0;
        case (out_state_reg)
            O_IDLE: begin
                if (!fifo_empty) begin
                    load           = 1'b1;
                    req_next       = (OUT_PHASES == PH_2) ? !req_reg : 1'b1;
                    out_state_next = O_REQ;
                end
            end
            O_REQ: begin
                if (OUT_PHASES == PH_2) begin
                    if (ack_s == req_reg) begin
                        pop            = 1'b1;
                        out_state_next = O_IDLE;
                    end
                end else if (ack_s) begin
                    pop            = 1'b1;
                    req_next       = 1'b0;
                    out_state_next = O_RTZ;
                end
            end
            O_RTZ: begin
                if (!ack_s) begin
                    out_state_next = O_IDLE;
                end
            end
            default: out_state_next = O_IDLE;
        endcase
    end

    ctl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (push),
        .push_data (data_i),
        .pop       (pop),
        .load      (load),
        .head_data (data_o),
        .count     (count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ack_i   = ack_reg;
    assign req_o   = req_reg;
    assign full_o  = fifo_full;
    assign empty_o = fifo_empty;

endmodule

// File: tb/tb_ctl_pipe.sv
// Scoreboard bench for ctl_pipe: four instances (4/4, 2/4, 4/2, 4/4 with sync),
// each with a downstream peer that checks every offered token against a queue.
module tb_ctl_pipe;

    logic       clk;
    logic [3:0] rst_i;
    logic [3:0] req_i;
    logic [7:0] data_i   [4];
    logic       ack_i_w  [4];
    logic       req_o_w  [4];
    logic [7:0] data_o_w [4];
    logic [2:0] count_w  [4];
    logic       full_w   [4];
    logic       empty_w  [4];

    int ack_limit [4];
    int got       [4] = '{default: 0};
    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] q3 [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void sb_push(input int idx, input logic [7:0] d);
        case (idx)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic void sb_take(input int idx, input logic [7:0] d);
        logic [7:0] e;
        e = 8'h00;
        if (qsize(idx) == 0) begin
            checks++;
            errors++;
            $display("FAIL sb%0d: got token %h want none", idx, d);
        end else begin
            case (idx)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            chk($sformatf("sb%0d_data", idx), 32'(d), 32'(e));
        end
        got[idx]++;
        $display("tok inst=%0d data=%h expected=%h", idx, d, e);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        logic ack_r;

        ctl_pipe #(
            .WIDTH       (8),
            .DEPTH       (4),
            .IN_PHASES   ((gi == 1) ? 2 : 4),
            .OUT_PHASES  ((gi == 2) ? 2 : 4),
            .SYNC_STAGES ((gi == 3) ? 2 : 0)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst_i[gi]),
            .req_i   (req_i[gi]),
            .data_i  (data_i[gi]),
            .ack_i   (ack_i_w[gi]),
            .req_o   (req_o_w[gi]),
            .data_o  (data_o_w[gi]),
            .ack_o   (ack_r),
            .count_o (count_w[gi]),
            .full_o  (full_w[gi]),
            .empty_o (empty_w[gi])
        );

        // Downstream peer: acknowledges while got < ack_limit, one cycle after seeing a request.
        initial begin
            ack_r = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_i[gi]) begin
                    ack_r = 1'b0;
                end else if (gi == 2) begin
                    if ((req_o_w[gi] != ack_r) && (got[gi] < ack_limit[gi])) begin
                        sb_take(gi, data_o_w[gi]);
                        ack_r = req_o_w[gi];
                    end
                end else if (req_o_w[gi] && !ack_r && (got[gi] < ack_limit[gi])) begin
                    sb_take(gi, data_o_w[gi]);
                    ack_r = 1'b1;
                end else if (!req_o_w[gi] && ack_r) begin
                    ack_r = 1'b0;
                end
            end
        end
    end

    task automatic wait_ack(input int idx, input logic v, input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ack_i_w[idx] == v) break;
        end
        chk(name, 32'(ack_i_w[idx]), 32'(v));
    endtask

    task automatic wait_empty(input int idx, input string name);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (empty_w[idx] && (qsize(idx) == 0)) break;
        end
        chk(name, 32'(empty_w[idx]), 32'd1);
    endtask

    task automatic push4(input int idx, input logic [7:0] d);
        @(negedge clk);
        data_i[idx] = d;
        req_i[idx]  = 1'b1;
        sb_push(idx, d);
        wait_ack(idx, 1'b1, "ack_rise");
        req_i[idx] = 1'b0;
        wait_ack(idx, 1'b0, "ack_fall");
    endtask

    task automatic push2(input int idx, input logic [7:0] d);
        @(negedge clk);
        data_i[idx] = d;
        req_i[idx]  = ~req_i[idx];
        sb_push(idx, d);
        wait_ack(idx, req_i[idx], "ack_toggle");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_i = 4'hF;
        req_i = 4'h0;
        for (int i = 0; i < 4; i++) begin
            data_i[i]    = 8'h00;
            ack_limit[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_i = 4'h0;

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_req_o%0d", i), 32'(req_o_w[i]), 32'd0);
            chk($sformatf("rst_ack_i%0d", i), 32'(ack_i_w[i]), 32'd0);
            chk($sformatf("rst_data_o%0d", i), 32'(data_o_w[i]), 32'd0);
            chk($sformatf("rst_count%0d", i), 32'(count_w[i]), 32'd0);
            chk($sformatf("rst_full%0d", i), 32'(full_w[i]), 32'd0);
            chk($sformatf("rst_empty%0d", i), 32'(empty_w[i]), 32'd1);
        end

        // 4/4: three pushes with downstream stalled
        push4(0, 8'h11);
        push4(0, 8'h22);
        push4(0, 8'h33);
        repeat (2) @(negedge clk);
        chk("hold_count", 32'(count_w[0]), 32'd3);
        chk("hold_req_o", 32'(req_o_w[0]), 32'd1);
        chk("hold_data_o", 32'(data_o_w[0]), 32'h11);

        // Fill, then a fifth request must wait for one downstream transfer
        push4(0, 8'h44);
        chk("fill_full", 32'(full_w[0]), 32'd1);
        @(negedge clk);
        data_i[0] = 8'h55;
        req_i[0]  = 1'b1;
        sb_push(0, 8'h55);
        repeat (3) @(negedge clk);
        chk("fifth_blocked_ack", 32'(ack_i_w[0]), 32'd0);
        chk("fifth_blocked_full", 32'(full_w[0]), 32'd1);
        ack_limit[0] = 1;
        wait_ack(0, 1'b1, "fifth_ack_rise");
        req_i[0] = 1'b0;
        wait_ack(0, 1'b0, "fifth_ack_fall");
        chk("fifth_count", 32'(count_w[0]), 32'd4);
        chk("fifth_full", 32'(full_w[0]), 32'd1);
        ack_limit[0] = 1000;
        wait_empty(0, "fill_drain");
        chk("fill_got", 32'(got[0]), 32'd5);

        // 2-phase upstream to 4-phase downstream
        ack_limit[1] = 1000;
        for (int i = 0; i < 4; i++) begin
            push2(1, 8'hA0 + 8'(i));
        end
        wait_empty(1, "conv24_drain");
        chk("conv24_got", 32'(got[1]), 32'd4);

        // 4/2: simultaneous write and pop at count 2, then stream across wraps
        push4(2, 8'h20);
        push4(2, 8'h21);
        repeat (2) @(negedge clk);
        chk("sim_pre_count", 32'(count_w[2]), 32'd2);
        @(posedge clk);
        #1;
        ack_limit[2] = 1;
        @(negedge clk);
        data_i[2] = 8'h22;
        req_i[2]  = 1'b1;
        sb_push(2, 8'h22);
        @(negedge clk);
        chk("sim_count", 32'(count_w[2]), 32'd2);
        chk("sim_ack", 32'(ack_i_w[2]), 32'd1);
        req_i[2] = 1'b0;
        wait_ack(2, 1'b0, "sim_ack_fall");
        ack_limit[2] = 1000;
        for (int i = 3; i < 20; i++) begin
            push4(2, 8'h20 + 8'(i));
        end
        wait_empty(2, "wrap_drain");
        chk("wrap_got", 32'(got[2]), 32'd20);

        // Reset while a transfer is pending
        ack_limit[0] = got[0];
        push4(0, 8'h81);
        push4(0, 8'h82);
        push4(0, 8'h83);
        repeat (2) @(negedge clk);
        chk("prerst_req_o", 32'(req_o_w[0]), 32'd1);
        chk("prerst_count", 32'(count_w[0]), 32'd3);
        rst_i[0] = 1'b1;
        q0.delete();
        @(negedge clk);
        rst_i[0] = 1'b0;
        chk("midrst_req_o", 32'(req_o_w[0]), 32'd0);
        chk("midrst_ack_i", 32'(ack_i_w[0]), 32'd0);
        chk("midrst_data_o", 32'(data_o_w[0]), 32'd0);
        chk("midrst_empty", 32'(empty_w[0]), 32'd1);
        chk("midrst_count", 32'(count_w[0]), 32'd0);
        ack_limit[0] = 1000;
        push4(0, 8'h77);
        wait_empty(0, "postrst_drain");

        // SYNC_STAGES=2 latencies
        @(negedge clk);
        data_i[3] = 8'h5A;
        req_i[3]  = 1'b1;
        sb_push(3, 8'h5A);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ack_i_w[3]) begin
                lat = n;
                break;
            end
        end
        chk("sync_ack_latency", 32'(lat), 32'd3);
        chk("sync_req_o_early", 32'(req_o_w[3]), 32'd0);
        @(negedge clk);
        chk("sync_empty_to_req", 32'(req_o_w[3]), 32'd1);
        chk("sync_data_o", 32'(data_o_w[3]), 32'h5A);
        req_i[3] = 1'b0;
        wait_ack(3, 1'b0, "sync_ack_fall");
        ack_limit[3] = 1000;
        wait_empty(3, "sync_drain");

        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("queue_left%0d", i), 32'(qsize(i)), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
